// File: rtl/image_bram_seq_if.sv
// Bundle of every non-clock signal of the image BRAM sequencer: commands, load stream,
// pixel stream, BRAM port and status. master = sequencer side, slave = environment side.
interface image_bram_seq_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          START_LOAD;
    logic          START_READ;
    logic          LOAD_VALID;
    logic [DW-1:0] LOAD_DATA;
    logic          LOAD_READY;
    logic          PIX_READY;
    logic          PIX_VALID;
    logic [DW-1:0] PIX_DATA;
    logic          PIX_LAST;
    logic [AW-1:0] BRAM_ADDR;
    logic [DW-1:0] BRAM_DI;
    logic          BRAM_EN;
    logic          BRAM_WE;
    logic [DW-1:0] BRAM_DO;
    logic          BUSY;
    logic          DONE;

    modport master (
        input  START_LOAD, START_READ, LOAD_VALID, LOAD_DATA, PIX_READY, BRAM_DO,
        output LOAD_READY, PIX_VALID, PIX_DATA, PIX_LAST,
        output BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE, BUSY, DONE
    );

    modport slave (
        output START_LOAD, START_READ, LOAD_VALID, LOAD_DATA, PIX_READY, BRAM_DO,
        input  LOAD_READY, PIX_VALID, PIX_DATA, PIX_LAST,
        input  BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE, BUSY, DONE
    );
endinterface

// File: rtl/image_bram_seq.sv
// Sole owner of a 169 x 8 image BRAM: LOAD fills it from a byte stream, READ streams
// every pixel in address order to the neuron datapath with full backpressure.
//
// state  | meaning
// IDLE   | waiting for START_LOAD / START_READ, BRAM disabled
// LOAD   | accepting bytes, one BRAM write per accepted byte
// PRIME  | issue read of address 0
// STREAM | capture BRAM_DO into the pixel register, advance address on adv
// DRAIN  | last pixel held until the consumer takes it
module image_bram_seq #(
    parameter int DEPTH = 169,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic            CLK,
    input  logic            RST,
    image_bram_seq_if.master bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_di;
    logic [DW-1:0] r_pix_data;
    logic          r_en;
    logic          r_we;
    logic          r_pix_valid;
    logic          r_pix_last;
    logic          r_done;
    logic          w_adv;
    logic          w_load_acc;

    assign w_adv      = !r_pix_valid || bus.PIX_READY;
    assign w_load_acc = (r_state == S_LOAD) && bus.LOAD_VALID;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.START_LOAD)      w_next = S_LOAD;
                else if (bus.START_READ) w_next = S_PRIME;
            end
            S_LOAD:   if (w_load_acc && r_wr_addr == LAST_ADDR) w_next = S_IDLE;
            S_PRIME:  w_next = S_STREAM;
            S_STREAM: if (w_adv && r_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN:  if (r_pix_valid && bus.PIX_READY) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_addr   <= '0;
            r_addr      <= '0;
            r_di        <= '0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_en      <= 1'b0;
                    r_we      <= 1'b0;
                    r_wr_addr <= '0;
                end
                S_LOAD: begin
                    r_en <= w_load_acc;
                    r_we <= w_load_acc;
                    if (w_load_acc) begin
                        r_addr    <= r_wr_addr;
                        r_di      <= bus.LOAD_DATA;
                        r_wr_addr <= r_wr_addr + 1'b1;
                        r_done    <= (r_wr_addr == LAST_ADDR);
                    end
                end
                S_PRIME: begin
                    r_addr <= '0;
                    r_en   <= 1'b1;
                    r_we   <= 1'b0;
                end
                // On a stall the address holds, so the BRAM keeps re-reading it and BRAM_DO stays put.
                S_STREAM: begin
                    if (w_adv) begin
                        r_pix_data  <= bus.BRAM_DO;
                        r_pix_valid <= 1'b1;
                        r_pix_last  <= (r_addr == LAST_ADDR);
                        if (r_addr < LAST_ADDR) r_addr <= r_addr + 1'b1;
                        else                    r_en   <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_pix_valid && bus.PIX_READY) begin
                        r_pix_valid <= 1'b0;
                        r_pix_last  <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_en <= 1'b0;
                    r_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LOAD_READY = (r_state == S_LOAD);
    assign bus.BUSY       = (r_state != S_IDLE);
    assign bus.DONE       = r_done;
    assign bus.BRAM_ADDR  = r_addr;
    assign bus.BRAM_DI    = r_di;
    assign bus.BRAM_EN    = r_en;
    assign bus.BRAM_WE    = r_we;
    assign bus.PIX_VALID  = r_pix_valid;
    assign bus.PIX_DATA   = r_pix_data;
    assign bus.PIX_LAST   = r_pix_last;
endmodule

// File: tb/tb_image_bram_seq.sv
// Bench for image_bram_seq: behavioural negedge BRAM, reference image of accepted bytes,
// and a pixel scoreboard filled at READ start and drained on every handshake.
module tb_image_bram_seq;
    localparam int DEPTH = 169;
    localparam int AW = 8;
    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int total = 0;
    int bad = 0;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_img [0:DEPTH-1];
    logic [8:0] sb [$];

    image_bram_seq_if #(.AW(AW), .DW(DW)) bus ();

    image_bram_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.BRAM_EN) begin
            total++;
            if (bus.BRAM_ADDR >= AW'(DEPTH)) begin
                bad++;
                $display("FAIL bram_range addr=%0d limit=%0d", bus.BRAM_ADDR, DEPTH - 1);
            end
            if (bus.BRAM_WE) mem[bus.BRAM_ADDR] <= bus.BRAM_DI;
            else             bus.BRAM_DO <= mem[bus.BRAM_ADDR];
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({bus.BRAM_ADDR, bus.BRAM_DI, bus.BRAM_EN, bus.BRAM_WE, bus.PIX_VALID, bus.PIX_LAST,
             bus.PIX_DATA, bus.LOAD_READY, bus.BUSY, bus.DONE} !== '0) begin
            bad++;
            $display("FAIL reset_outputs addr=%h di=%h en=%b we=%b pv=%b pl=%b pd=%h lr=%b busy=%b done=%b exp all 0",
                     bus.BRAM_ADDR, bus.BRAM_DI, bus.BRAM_EN, bus.BRAM_WE, bus.PIX_VALID,
                     bus.PIX_LAST, bus.PIX_DATA, bus.LOAD_READY, bus.BUSY, bus.DONE);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (bus.BUSY !== 1'b0 || bus.LOAD_READY !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b lr=%b exp 0 0", bus.BUSY, bus.LOAD_READY);
        end
    endtask

    task automatic do_load(input int gap, input bit both, input bit rd_mid);
        int n = 0;
        int cyc = 0;
        logic acc;
        logic [DW-1:0] d;
        bus.START_LOAD = 1'b1;
        bus.START_READ = both;
        @(posedge CLK); #1;
        bus.START_LOAD = 1'b0;
        bus.START_READ = 1'b0;
        while (n < DEPTH && cyc < 2000) begin
            total++;
            if (bus.BUSY !== 1'b1 || bus.LOAD_READY !== 1'b1 || bus.DONE !== 1'b0 || bus.PIX_VALID !== 1'b0) begin
                bad++;
                $display("FAIL load_state n=%0d busy=%b lr=%b done=%b pv=%b exp 1 1 0 0",
                         n, bus.BUSY, bus.LOAD_READY, bus.DONE, bus.PIX_VALID);
            end
            bus.START_READ = rd_mid && (cyc == 5);
            acc = (cyc % gap == 0);
            d = (gap == 1) ? DW'(n) : DW'($urandom_range(0, 255));
            bus.LOAD_VALID = acc;
            bus.LOAD_DATA = d;
            if (acc) ref_img[n] = d;
            @(posedge CLK); #1;
            cyc++;
            total++;
            if (bus.BRAM_WE !== acc || bus.BRAM_EN !== acc) begin
                bad++;
                $display("FAIL load_we cyc=%0d we=%b en=%b exp %b", cyc, bus.BRAM_WE, bus.BRAM_EN, acc);
            end
            if (acc) begin
                total++;
                if (bus.BRAM_ADDR !== AW'(n) || bus.BRAM_DI !== d) begin
                    bad++;
                    $display("FAIL load_write addr=%0d di=%h exp %0d %h", bus.BRAM_ADDR, bus.BRAM_DI, n, d);
                end
                n++;
            end
        end
        bus.LOAD_VALID = 1'b0;
        bus.START_READ = 1'b0;
        total++;
        if (cyc >= 2000) begin
            bad++;
            $display("FAIL load_timeout accepted=%0d exp %0d", n, DEPTH);
        end
        total++;
        if (bus.DONE !== 1'b1 || bus.LOAD_READY !== 1'b0 || bus.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL load_done done=%b lr=%b busy=%b exp 1 0 0", bus.DONE, bus.LOAD_READY, bus.BUSY);
        end
        repeat (3) begin
            @(posedge CLK); #1;
            total++;
            if (bus.DONE !== 1'b0 || bus.BRAM_EN !== 1'b0 || bus.PIX_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
                bad++;
                $display("FAIL load_after done=%b en=%b pv=%b busy=%b exp 0 0 0 0",
                         bus.DONE, bus.BRAM_EN, bus.PIX_VALID, bus.BUSY);
            end
        end
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: ready always except 5-cycle stall on the last pixel
    task automatic do_read(input int mode, input int stop_at);
        int got = 0;
        int cyc = 0;
        int stall = 0;
        logic rdy;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic pl = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [AW-1:0] pa = '0;
        logic [8:0] e;
        for (int i = 0; i < DEPTH; i++) sb.push_back({(i == DEPTH - 1), ref_img[i]});
        bus.PIX_READY = 1'b0;
        bus.START_READ = 1'b1;
        @(posedge CLK); #1;
        bus.START_READ = 1'b0;
        total++;
        if (bus.PIX_VALID !== 1'b0 || bus.BUSY !== 1'b1) begin
            bad++;
            $display("FAIL read_prime pv=%b busy=%b exp 0 1", bus.PIX_VALID, bus.BUSY);
        end
        @(posedge CLK); #1;
        total++;
        if (bus.PIX_VALID !== 1'b0 || bus.BRAM_EN !== 1'b1 || bus.BRAM_WE !== 1'b0 || bus.BRAM_ADDR !== '0) begin
            bad++;
            $display("FAIL read_issue pv=%b en=%b we=%b addr=%0d exp 0 1 0 0",
                     bus.PIX_VALID, bus.BRAM_EN, bus.BRAM_WE, bus.BRAM_ADDR);
        end
        while (got < DEPTH && cyc < 3000 && !(stop_at > 0 && got == stop_at)) begin
            case (mode)
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'b1;
            endcase
            if (mode == 2 && bus.PIX_VALID === 1'b1 && bus.PIX_LAST === 1'b1 && stall < 5) begin
                rdy = 1'b0;
                stall++;
                total++;
                if (bus.BRAM_EN !== 1'b0 || bus.BUSY !== 1'b1) begin
                    bad++;
                    $display("FAIL last_stall en=%b busy=%b exp 0 1", bus.BRAM_EN, bus.BUSY);
                end
            end
            if (mode == 0 && cyc > 0) begin
                total++;
                if (bus.PIX_VALID !== 1'b1) begin
                    bad++;
                    $display("FAIL read_gap cyc=%0d pv=%b exp 1", cyc, bus.PIX_VALID);
                end
            end
            if (pv && !pr) begin
                total++;
                if (bus.PIX_VALID !== 1'b1 || bus.PIX_DATA !== pd || bus.PIX_LAST !== pl || bus.BRAM_ADDR !== pa) begin
                    bad++;
                    $display("FAIL stall_hold pv=%b pd=%h pl=%b addr=%0d exp 1 %h %b %0d",
                             bus.PIX_VALID, bus.PIX_DATA, bus.PIX_LAST, bus.BRAM_ADDR, pd, pl, pa);
                end
            end
            total++;
            if (bus.DONE !== 1'b0) begin
                bad++;
                $display("FAIL read_early_done got=%0d done=%b exp 0", got, bus.DONE);
            end
            bus.PIX_READY = rdy;
            if (bus.PIX_VALID === 1'b1 && rdy) begin
                e = sb.pop_front();
                total++;
                if (bus.PIX_DATA !== e[7:0] || bus.PIX_LAST !== e[8]) begin
                    bad++;
                    $display("FAIL pixel idx=%0d data=%h last=%b exp %h %b",
                             got, bus.PIX_DATA, bus.PIX_LAST, e[7:0], e[8]);
                end
                got++;
            end
            pv = bus.PIX_VALID;
            pr = rdy;
            pd = bus.PIX_DATA;
            pl = bus.PIX_LAST;
            pa = bus.BRAM_ADDR;
            @(posedge CLK); #1;
            cyc++;
        end
        total++;
        if (cyc >= 3000) begin
            bad++;
            $display("FAIL read_timeout got=%0d exp %0d", got, DEPTH);
        end
        if (stop_at > 0 && got == stop_at) begin
            RST = 1'b1;
            bus.PIX_READY = 1'b0;
            @(posedge CLK); #1;
            total++;
            if (bus.PIX_VALID !== 1'b0 || bus.BRAM_EN !== 1'b0 || bus.BUSY !== 1'b0 ||
                bus.DONE !== 1'b0 || bus.BRAM_ADDR !== '0) begin
                bad++;
                $display("FAIL mid_reset pv=%b en=%b busy=%b done=%b addr=%0d exp 0 0 0 0 0",
                         bus.PIX_VALID, bus.BRAM_EN, bus.BUSY, bus.DONE, bus.BRAM_ADDR);
            end
            RST = 1'b0;
            sb.delete();
            @(posedge CLK); #1;
            return;
        end
        if (mode == 2) begin
            total++;
            if (stall != 5) begin
                bad++;
                $display("FAIL last_stall_seen cycles=%0d exp 5", stall);
            end
        end
        total++;
        if (bus.DONE !== 1'b1 || bus.PIX_VALID !== 1'b0 || bus.PIX_LAST !== 1'b0 || bus.BRAM_EN !== 1'b0) begin
            bad++;
            $display("FAIL read_done done=%b pv=%b pl=%b en=%b exp 1 0 0 0",
                     bus.DONE, bus.PIX_VALID, bus.PIX_LAST, bus.BRAM_EN);
        end
        bus.PIX_READY = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL read_after done=%b busy=%b exp 0 0", bus.DONE, bus.BUSY);
        end
    endtask

    task automatic test_load_readback();
        do_load(1, 1'b0, 1'b0);
        do_read(0, 0);
    endtask

    task automatic test_backpressure();
        do_read(1, 0);
    endtask

    task automatic test_gapped_load();
        do_load(3, 1'b0, 1'b0);
        do_read(0, 0);
    endtask

    task automatic test_arbitration();
        do_load(1, 1'b1, 1'b1);
        do_read(1, 0);
    endtask

    task automatic test_reset_mid_stream();
        do_read(0, 50);
        do_read(0, 0);
    endtask

    task automatic test_last_stall();
        do_read(2, 0);
    endtask

    initial begin
        bus.START_LOAD = 1'b0;
        bus.START_READ = 1'b0;
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_DATA  = '0;
        bus.PIX_READY  = 1'b0;
        bus.BRAM_DO    = '0;
        test_reset();
        test_load_readback();
        test_backpressure();
        test_gapped_load();
        test_arbitration();
        test_reset_mid_stream();
        test_last_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/image_bram_seq.md
Name: image_bram_seq

Overview:
- Sequencer for one 169-entry x 8-bit image BRAM (13x13 pixel tile) feeding the ANN input layer.
- Two modes, each started by a one-cycle command:
  - LOAD: fills the BRAM from a valid/ready byte stream.
  - READ: streams all pixels in address order to the neuron datapath through a valid/ready output with full backpressure.
- Sole owner of the BRAM port. The BRAM registers writes and read data on the negedge of CLK.

Parameters:
DEPTH, 169, number of pixels per image (last address DEPTH-1)
AW, 8, BRAM address width
DW, 8, pixel width

Ports:
CLK  in  1  clock; all controller logic on posedge
RST  in  1  synchronous active-high reset
START_LOAD  in  1  one-cycle pulse; begin LOAD (sampled in IDLE only)
START_READ  in  1  one-cycle pulse; begin READ (sampled in IDLE only)
LOAD_VALID  in  1  input byte valid
LOAD_DATA  in  DW  input byte
LOAD_READY  out  1  controller accepts byte this cycle
PIX_READY  in  1  consumer accepts PIX_DATA
PIX_VALID  out  1  PIX_DATA valid
PIX_DATA  out  DW  pixel
PIX_LAST  out  1  qualifies the pixel from address DEPTH-1
BRAM_ADDR  out  AW  BRAM address (registered)
BRAM_DI  out  DW  BRAM write data (registered)
BRAM_EN  out  1  BRAM enable (registered)
BRAM_WE  out  1  BRAM write enable (registered)
BRAM_DO  in  DW  BRAM read data (valid from negedge after address issue)
BUSY  out  1  high in any state except IDLE
DONE  out  1  one-cycle pulse at end of LOAD or READ

Behaviour:
- Reset values:
  - State IDLE.
  - BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE, PIX_VALID, PIX_LAST, PIX_DATA, LOAD_READY, BUSY and DONE are all 0.
  - Reset does not clear BRAM contents.
- States: IDLE, LOAD, PRIME, STREAM, DRAIN.
- IDLE:
  - START_LOAD: go to LOAD with wr_addr=0.
  - START_READ: go to PRIME with rd_addr=0.
  - Both asserted together: LOAD wins and START_READ is dropped.
  - Commands in any other state are ignored.
- LOAD:
  - LOAD_READY=1, driven combinationally from state.
  - On posedge with LOAD_VALID: register BRAM_ADDR=wr_addr, BRAM_DI=LOAD_DATA, BRAM_EN=1, BRAM_WE=1. The write completes on the following negedge.
  - Otherwise BRAM_EN=BRAM_WE=0.
  - Byte at wr_addr=DEPTH-1: next state IDLE, DONE pulses 1 cycle later (same cycle the final EN/WE are high). LOAD_READY is 0 from that point.
  - Exactly DEPTH bytes accepted per LOAD.
- PRIME (1 cycle): register BRAM_ADDR=0, BRAM_EN=1, BRAM_WE=0, then go to STREAM.
- STREAM:
  - Let adv = !PIX_VALID || PIX_READY.
  - On posedge with adv:
    - PIX_DATA<=BRAM_DO.
    - PIX_VALID<=1.
    - PIX_LAST<=(BRAM_ADDR==DEPTH-1).
    - If BRAM_ADDR<DEPTH-1: BRAM_ADDR<=BRAM_ADDR+1. Otherwise BRAM_EN<=0 and go to DRAIN.
  - Without adv: BRAM_ADDR and BRAM_EN hold. The BRAM re-reads the same address, so BRAM_DO stays stable and PIX_DATA/PIX_LAST hold.
  - Latency: START_READ at edge k, first PIX_VALID at edge k+2.
  - With PIX_READY held high: one pixel per cycle, DEPTH consecutive valid cycles.
- DRAIN:
  - On PIX_VALID && PIX_READY (the last pixel): PIX_VALID<=0, PIX_LAST<=0, DONE<=1 for one cycle, go to IDLE.
- PIX_VALID never drops without a handshake. PIX_DATA is stable while PIX_VALID && !PIX_READY.
- Address never wraps: BRAM_ADDR never exceeds DEPTH-1, and no access occurs outside LOAD/PRIME/STREAM.
- BRAM_WE=1 only in LOAD. BRAM_EN=0 in IDLE and DRAIN.
- RST mid-operation: next edge forces IDLE with all outputs at reset values. A partially loaded image remains in the BRAM. No DONE is generated.

Test Plan:
- Load and readback: load bytes 0x00..0xA8 with LOAD_VALID held high, then START_READ with PIX_READY=1 -> DONE after 169 accepted bytes; 169 consecutive PIX_VALID cycles with PIX_DATA 0x00..0xA8; PIX_LAST only on 0xA8; DONE 1 cycle after the last handshake.
- Backpressure: READ with PIX_READY toggling 1,0,0,1 -> every pixel delivered exactly once, in order, with no duplicates; PIX_DATA/PIX_LAST stable across stall cycles; BRAM_ADDR frozen during stalls.
- Gapped load: LOAD_VALID asserted every third cycle -> BRAM_WE pulses only on accepted bytes; readback matches the input; BUSY high throughout; DONE exactly once.
- Command arbitration: START_LOAD and START_READ in the same cycle -> LOAD entered. START_READ during LOAD -> ignored; no PIX_VALID until a fresh START_READ in IDLE.
- Reset mid-stream: RST after 50 pixels accepted -> next cycle PIX_VALID=0, BRAM_EN=0, BUSY=0, DONE=0. A subsequent READ restarts at address 0 and returns the previously loaded data.
- Last-pixel stall: hold PIX_READY=0 on the pixel from address 168 for 5 cycles -> state DRAIN, BRAM_EN=0, PIX_LAST=1 held. DONE fires only after PIX_READY rises.
